imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 20 ++
 rtl/imem_word_assembler.sv | 43 ++++
 rtl/imem_loader.sv | 151 +++++++++++++++
 tb/tb_imem_loader.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR_LO,
      S_HDR_HI,
      S_DATA,
      S_CSUM,
      S_DONE,
      S_ERR
   } state_e;

   localparam int HDR_BYTES  = 2;
   localparam int WORD_BYTES = 4;
   localparam int CNT_W      = 8 * HDR_BYTES;
   localparam int WORD_W     = 8 * WORD_BYTES;
   localparam int BCNT_W     = $clog2(WORD_BYTES);

endpackage

// File: rtl/imem_word_assembler.sv
// Little-endian byte-to-word shifter; flags the byte that completes a word.
module imem_word_assembler
   import imem_loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              byte_en,
   input  logic [7:0]        byte_data,
   output logic              word_last,
   output logic [WORD_W-1:0] word_nxt
);

   logic [WORD_W-1:0] sr_q, sr_d;
   logic [BCNT_W-1:0] cnt_q, cnt_d;

   // Bytes enter at the top so the first byte ends up in bits 7:0.
   assign word_nxt  = {byte_data, sr_q[WORD_W-1:8]};
   assign word_last = byte_en && (cnt_q == BCNT_W'(WORD_BYTES - 1));

   always_comb begin
      sr_d  = sr_q;
      cnt_d = cnt_q;
      if (clear) begin
         sr_d  = '0;
         cnt_d = '0;
      end else if (byte_en) begin
         sr_d  = word_nxt;
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr_q  <= '0;
         cnt_q <= '0;
      end else begin
         sr_q  <= sr_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed program into instruction memory and holds the core until done.
// Optional trailing XOR checksum byte enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          DEPTH_WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        byte_ready,
   output logic        imem_we,
   output logic [31:0] imem_addr,
   output logic [31:0] imem_wdata,
   output logic        cpu_hold,
   output logic        done,
   output logic        error
);

   localparam logic [31:0] DEPTH_U = 32'(DEPTH_WORDS);
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam state_e END_ST = S_CSUM;
`else
   localparam state_e END_ST = S_DONE;
`endif

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  n_q, n_d, wcnt_q, wcnt_d, hdr_n;
   logic [31:0]       addr_q, addr_d, wdata_q, wdata_d;
   logic              we_q, we_d, ready_q, ready_d, hold_q, hold_d;
   logic              done_q, done_d, err_q, err_d;
   logic              byte_acc, data_acc, launch, word_last;
   logic [WORD_W-1:0] word_nxt;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]        csum_q, csum_d;
`endif

   assign byte_acc = byte_valid && ready_q;
   // Once all N words are assembled, stray bytes must not start another word.
   assign data_acc = (state_q == S_DATA) && byte_acc && (wcnt_q != n_q);
   assign launch   = start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);

   imem_word_assembler u_asm (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (launch),
      .byte_en   (data_acc),
      .byte_data (byte_data),
      .word_last (word_last),
      .word_nxt  (word_nxt)
   );

   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      wcnt_d  = wcnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_d    = word_last;
      hdr_n   = {byte_data, n_q[7:0]};
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_d  = data_acc ? (csum_q ^ byte_data) : csum_q;
`endif
      if (word_last) begin
         wdata_d = word_nxt;
         wcnt_d  = wcnt_q + 1'b1;
      end
      if (we_q) addr_d = addr_q + 32'd4;

      case (state_q)
         S_IDLE, S_DONE, S_ERR: if (start) state_d = S_HDR_LO;
         S_HDR_LO: if (byte_acc) begin
            n_d[7:0] = byte_data;
            state_d  = S_HDR_HI;
         end
         S_HDR_HI: if (byte_acc) begin
            n_d = hdr_n;
            if (32'(hdr_n) > DEPTH_U) state_d = S_ERR;
            else if (hdr_n == '0)     state_d = END_ST;
            else                      state_d = S_DATA;
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         // Leave on the last byte so a trailing byte in the write cycle is the checksum.
         S_DATA: if (word_last && (wcnt_q + 1'b1 == n_q)) state_d = S_CSUM;
         S_CSUM: if (byte_acc) state_d = (byte_data == csum_q) ? S_DONE : S_ERR;
`else
         // Stay through the final write cycle so done never overlaps imem_we.
         S_DATA: if (we_q && (wcnt_q == n_q)) state_d = S_DONE;
`endif
         default: state_d = S_IDLE;
      endcase

      if (launch) begin
         addr_d = BASE_ADDR;
         wcnt_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_d = '0;
`endif
      end

      ready_d = (state_d == S_HDR_LO) || (state_d == S_HDR_HI) ||
                (state_d == S_DATA)   || (state_d == S_CSUM);
      hold_d  = (state_d != S_DONE);
      done_d  = (state_d == S_DONE);
      err_d   = (state_d == S_ERR);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         n_q     <= '0;
         wcnt_q  <= '0;
         addr_q  <= BASE_ADDR;
         wdata_q <= '0;
         we_q    <= 1'b0;
         ready_q <= 1'b0;
         hold_q  <= 1'b1;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         wcnt_q  <= wcnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         ready_q <= ready_d;
         hold_q  <= hold_d;
         done_q  <= done_d;
         err_q   <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end

   assign byte_ready = ready_q;
   assign imem_we    = we_q;
   assign imem_addr  = addr_q;
   assign imem_wdata = wdata_q;
   assign cpu_hold   = hold_q;
   assign done       = done_q;
   assign error      = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected writes come from the stream contents.
module tb_imem_loader;

   localparam logic [31:0] BASE  = 32'h0000_0000;
   localparam int          DEPTH = 1024;

   logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, byte_valid = 1'b0;
   logic [7:0]  byte_data = 8'h00;
   logic        byte_ready, imem_we, cpu_hold, done, error;
   logic [31:0] imem_addr, imem_wdata;

   int checks = 0, failures = 0;
   bit csum_bad = 1'b0;

   typedef struct {logic [31:0] addr; logic [31:0] data;} wr_t;
   wr_t         exp_q[$];
   wr_t         wlog[$];
   logic [31:0] words[$];

   imem_loader #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .byte_valid(byte_valid),
      .byte_data(byte_data), .byte_ready(byte_ready), .imem_we(imem_we),
      .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_hold(cpu_hold),
      .done(done), .error(error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Every write must match the head of the expected-write queue.
   always @(negedge clk) begin
      wr_t e;
      if (rst_n) begin
         chk("hold_is_not_done", {31'd0, cpu_hold}, {31'd0, !done});
         if (imem_we) begin
            wlog.push_back('{imem_addr, imem_wdata});
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_write actual=%h@%h required=none", imem_wdata, imem_addr);
            end else begin
               e = exp_q.pop_front();
               chk("wr_addr", imem_addr, e.addr);
               chk("wr_data", imem_wdata, e.data);
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      n = 0;
      for (int g = 0; g < gap; g++) begin
         @(posedge clk); #1;
      end
      byte_valid = 1'b1;
      byte_data  = b;
      while (!byte_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!byte_ready) begin
         checks++;
         failures++;
         $display("FAIL byte_accept_timeout actual=ready0 required=ready1");
         byte_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      byte_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic load(input logic [15:0] n, input int gapmax, input int start_at);
      logic [7:0] x, bt;
      int         k;
      x = 8'h00;
      k = 0;
      send_byte(n[7:0], 0);
      send_byte(n[15:8], 0);
      if (32'(n) > 32'(DEPTH)) return;
      foreach (words[i]) begin
         exp_q.push_back('{BASE + 32'(4 * i), words[i]});
         for (int b = 0; b < 4; b++) begin
            bt = words[i][8*b +: 8];
            x  = x ^ bt;
            send_byte(bt, k % (gapmax + 1));
            k++;
            if (k == start_at) pulse_start();
         end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(csum_bad ? (x ^ 8'h01) : x, 0);
`endif
   endtask

   task automatic wait_end(input string name, input bit exp_done);
      int n;
      n = 0;
      while (!(done || error) && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk({name, "_done"},    {31'd0, done},     {31'd0, exp_done});
      chk({name, "_error"},   {31'd0, error},    {31'd0, !exp_done});
      chk({name, "_hold"},    {31'd0, cpu_hold}, {31'd0, !exp_done});
      chk({name, "_ready"},   {31'd0, byte_ready}, 32'd0);
      chk({name, "_pending"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", {31'd0, byte_ready}, 32'd0);
      chk("rst_we",    {31'd0, imem_we},    32'd0);
      chk("rst_addr",  imem_addr,           BASE);
      chk("rst_wdata", imem_wdata,          32'd0);
      chk("rst_hold",  {31'd0, cpu_hold},   32'd1);
      chk("rst_done",  {31'd0, done},       32'd0);
      chk("rst_error", {31'd0, error},      32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("idle_ready", {31'd0, byte_ready}, 32'd0);

      // Two-word program: 02 00 13 00 00 00 93 00 10 00
      pulse_start();
      words = '{32'h0000_0013, 32'h0010_0093};
      load(16'd2, 0, -1);
      wait_end("two_words", 1'b1);
      chk("two_words_count", 32'(wlog.size()), 32'd2);
      if (wlog.size() >= 2) begin
         chk("lit_w0_addr", wlog[0].addr, 32'h0000_0000);
         chk("lit_w0_data", wlog[0].data, 32'h0000_0013);
         chk("lit_w1_addr", wlog[1].addr, 32'h0000_0004);
         chk("lit_w1_data", wlog[1].data, 32'h0010_0093);
      end

      // Restart from DONE; a start mid-payload must be ignored.
      pulse_start();
      chk("restart_done_clr", {31'd0, done}, 32'd0);
      chk("restart_ready",    {31'd0, byte_ready}, 32'd1);
      words = '{32'hDEAD_BEEF, 32'h0123_4567};
      load(16'd2, 0, 6);
      wait_end("start_in_data", 1'b1);

      // Oversize header: 1025 words
      pulse_start();
      words = {};
      load(16'd1025, 0, -1);
      wait_end("oversize", 1'b0);

      // Restart from ERR with idle gaps between bytes
      pulse_start();
      chk("err_cleared", {31'd0, error}, 32'd0);
      words = '{32'hCAFE_F00D, 32'h8000_0001, 32'h0F1E_2D3C};
      load(16'd3, 5, -1);
      wait_end("gaps", 1'b1);

      pulse_start();
      words = {};
      load(16'd0, 0, -1);
      wait_end("zero_words", 1'b1);

      // Reset after 6 payload bytes of N=2: only the first word ever lands.
      pulse_start();
      exp_q.push_back('{BASE, 32'h1122_3344});
      send_byte(8'h02, 0); send_byte(8'h00, 0);
      send_byte(8'h44, 0); send_byte(8'h33, 0); send_byte(8'h22, 0); send_byte(8'h11, 0);
      send_byte(8'hAA, 0); send_byte(8'hBB, 0);
      rst_n = 1'b0;
      #1;
      chk("midrst_we",    {31'd0, imem_we},  32'd0);
      chk("midrst_addr",  imem_addr,         BASE);
      chk("midrst_hold",  {31'd0, cpu_hold}, 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("midrst_pending", 32'(exp_q.size()), 32'd0);
      wlog.delete();
      pulse_start();
      words = '{32'hA5A5_5A5A};
      load(16'd1, 0, -1);
      wait_end("after_reset", 1'b1);
      chk("after_reset_count", 32'(wlog.size()), 32'd1);

      // Exactly DEPTH words is legal.
      pulse_start();
      words = {};
      for (int i = 0; i < DEPTH; i++) words.push_back(32'(i) * 32'h0001_0003 ^ 32'h5A00_0000);
      load(16'(DEPTH), 0, -1);
      wait_end("full_depth", 1'b1);

`ifdef IMEM_LOADER_CHECKSUM_EN
      pulse_start();
      words    = '{32'h0000_0013};
      csum_bad = 1'b0;
      load(16'd1, 0, -1);
      wait_end("csum_ok", 1'b1);
      pulse_start();
      csum_bad = 1'b1;
      load(16'd1, 0, -1);
      wait_end("csum_bad", 1'b0);
      csum_bad = 1'b0;
`endif

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
